serializer_gearbox: RTL and testbench
=====================================

Name: serializer_gearbox

Overview:
Fabric-logic, multi-channel parallel-to-narrow serializer. Converts CHANNELS lanes of DATA_W-bit words into OUT_W-bit slices per clock, LSB first, for feeding a DDR output register pair, a narrower SERDES, or a simulation/test path.
Adds a ready/valid input with a one-word holding buffer for gap-free streaming, idle-word insertion on underrun, word-boundary marking, and configurable width ratio.
Sits between TMDS/line encoders and the I/O primitive layer.

Parameters:
- CHANNELS, 3, number of parallel lanes sharing one handshake.
- DATA_W, 10, input word width per lane.
- OUT_W, 2, output slice width per lane. DATA_W % OUT_W must be 0. RATIO = DATA_W/OUT_W, RATIO >= 1.
- IDLE_WORD, 10'b1101010100, word loaded into every lane on underrun and after reset; width DATA_W.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- in_data  in  CHANNELS*DATA_W  lane c at [c*DATA_W +: DATA_W].
- in_valid  in  1  in_data valid.
- in_ready  out  1  block accepts in_data this cycle.
- serial_out  out  CHANNELS*OUT_W  lane c slice at [c*OUT_W +: OUT_W]; registered.
- word_start  out  1  high when serial_out carries slice 0 of a word (data or idle).
- underrun  out  1  one-cycle pulse when an idle word is loaded at a boundary.
- underrun_cnt  out  16  underrun count (see Optional Feature).

Behaviour:
- State: per-lane shift reg sh (DATA_W), shared slice index idx (0..RATIO-1), hold register hold_data + hold_valid.
- Reset (rst_n=0 at edge): sh=IDLE_WORD all lanes, idx=RATIO-1, hold_valid=0, serial_out=0, word_start=0, underrun=0, underrun_cnt=0. Reset mid-word abandons the word and any held word.
- last = (idx==RATIO-1). in_ready = !hold_valid || last (combinational; no dependence on in_valid).
- Accept = in_valid && in_ready.
- Each cycle out of reset:
  - serial_out <= sh[OUT_W-1:0] per lane.
  - word_start <= (idx==0).
  - If last: sh <= hold_valid ? hold_data : IDLE_WORD; idx <= 0; underrun <= !hold_valid.
  - Otherwise: sh <= sh >> OUT_W; idx <= idx+1; underrun <= 0.
- Hold: on accept, hold_data <= in_data and hold_valid <= 1. Else if last, hold_valid <= 0.
- Simultaneous load + accept: hold's word moves to sh while the new word enters hold, giving sustained 1 word per RATIO cycles with no idle.
- Latency: word accepted when hold is empty and the shifter is mid-word appears at the next boundary. Slice 0 reaches serial_out 1 cycle after the load edge.
- First post-reset load occurs on the first cycle (idx=RATIO-1). If no word is held, idle is output and underrun pulses.
- RATIO==1: last is always true. Each accepted word is output the cycle after it is loaded; idle fills any cycle without a held word.
- in_data sampled only on accept; changes while !in_ready are ignored.

Optional Feature:
- Macro SERIALIZER_UNDERRUN_CNT_EN.
- Defined: underrun_cnt increments on each underrun pulse and saturates at 16'hFFFF. Cleared only by reset.
- Undefined: counter not built; underrun_cnt tied to 0. The underrun pulse is unaffected.

Decomposition:
- Package serializer_pkg: function ser_ratio(DATA_W, OUT_W); TMDS idle constants (four control-period words), for use as IDLE_WORD.
- Sub-module serializer_lane: one lane's sh register and slice output, driven by shared load/shift/select controls.
- Top instantiates CHANNELS lanes and owns idx, the hold buffer, handshake, underrun logic and counter.

Test Plan:
- Post-reset idle: CHANNELS=1, DATA_W=10, OUT_W=2, in_valid=0 → serial_out repeats 00,01,01,01,11. word_start is high on each 00 slice. underrun pulses once per 5 cycles.
- Single word: in_valid one cycle with 10'h2A5 → next word slots give 01,01,10,10,10, then idle resumes with an underrun pulse at that boundary.
- Back-to-back: in_valid held high with 10'h2A5, 10'h15A, 10'h3FF,… → in_ready high only on last cycles after hold fills. No idle words between data words. underrun=0 throughout.
- Multi-channel: CHANNELS=3, lanes 10'h000/10'h3FF/10'h2A5 → lane slices 00/11/(01,01,10,10,10) in lockstep with one word_start.
- Ratio edges: OUT_W=10 → one word per cycle at full rate. OUT_W=1 → 10 single-bit slices LSB first for 10'h2A5 (1,0,1,0,0,1,0,1,0,1).
- Reset mid-word plus counter: assert rst_n=0 at idx=2 with a word held → outputs reset to 0 and the held word is dropped. With SERIALIZER_UNDERRUN_CNT_EN, 70000 idle words → underrun_cnt saturates at 16'hFFFF.

Source files
------------

// File: rtl/serializer_pkg.sv
// Shared helpers and TMDS control-period idle words for the serializer gearbox.
package serializer_pkg;

  localparam logic [9:0] TMDS_CTRL_00 = 10'b1101010100;
  localparam logic [9:0] TMDS_CTRL_01 = 10'b0010101011;
  localparam logic [9:0] TMDS_CTRL_10 = 10'b0101010100;
  localparam logic [9:0] TMDS_CTRL_11 = 10'b1010101011;

  function automatic int unsigned ser_ratio(input int unsigned data_w,
                                            input int unsigned out_w);
    return data_w / out_w;
  endfunction

endpackage

// File: rtl/serializer_lane.sv
// One lane of the gearbox: word shift register and registered LSB-first slice output.
module serializer_lane
  import serializer_pkg::*;
#(
  parameter int unsigned       DATA_W    = 10,
  parameter int unsigned       OUT_W     = 2,
  parameter logic [DATA_W-1:0] IDLE_WORD = TMDS_CTRL_00
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              use_hold,
  input  logic [DATA_W-1:0] hold_word,
  output logic [OUT_W-1:0]  slice
);

  logic [DATA_W-1:0] sh;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sh    <= IDLE_WORD;
      slice <= '0;
    end else begin
      slice <= sh[OUT_W-1:0];
      if (load) sh <= use_hold ? hold_word : IDLE_WORD;
      else      sh <= sh >> OUT_W;
    end
  end

endmodule

// File: rtl/serializer_gearbox.sv
// Multi-lane parallel-to-narrow serializer with one-word hold buffer and idle fill.
// Define SERIALIZER_UNDERRUN_CNT_EN to build the saturating underrun counter.
module serializer_gearbox
  import serializer_pkg::*;
#(
  parameter int unsigned       CHANNELS  = 3,
  parameter int unsigned       DATA_W    = 10,
  parameter int unsigned       OUT_W     = 2,
  parameter logic [DATA_W-1:0] IDLE_WORD = TMDS_CTRL_00
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [CHANNELS*DATA_W-1:0] in_data,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic [CHANNELS*OUT_W-1:0]  serial_out,
  output logic                       word_start,
  output logic                       underrun,
  output logic [15:0]                underrun_cnt
);

  localparam int unsigned      RATIO    = ser_ratio(DATA_W, OUT_W);
  localparam int unsigned      IDX_W    = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(RATIO - 1);

  logic [IDX_W-1:0]           idx;
  logic [CHANNELS*DATA_W-1:0] hold_data;
  logic                       hold_valid;
  logic                       last;
  logic                       accept;

  assign last     = (idx == IDX_LAST);
  assign in_ready = !hold_valid || last;
  assign accept   = in_valid && in_ready;

  // At a boundary the held word drains into the shifters on the same edge a
  // new word may enter hold, which is what keeps back-to-back words gap-free.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx        <= IDX_LAST;
      hold_data  <= '0;
      hold_valid <= 1'b0;
      word_start <= 1'b0;
      underrun   <= 1'b0;
    end else begin
      word_start <= (idx == '0);
      if (last) begin
        idx      <= '0;
        underrun <= !hold_valid;
      end else begin
        idx      <= idx + IDX_W'(1);
        underrun <= 1'b0;
      end
      if (accept) begin
        hold_data  <= in_data;
        hold_valid <= 1'b1;
      end else if (last) begin
        hold_valid <= 1'b0;
      end
    end
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
    serializer_lane #(
      .DATA_W   (DATA_W),
      .OUT_W    (OUT_W),
      .IDLE_WORD(IDLE_WORD)
    ) u_lane (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (last),
      .use_hold (hold_valid),
      .hold_word(hold_data[c*DATA_W +: DATA_W]),
      .slice    (serial_out[c*OUT_W +: OUT_W])
    );
  end

`ifdef SERIALIZER_UNDERRUN_CNT_EN
  logic [15:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n)                     cnt <= '0;
    else if (underrun && cnt != '1) cnt <= cnt + 16'd1;
  end

  assign underrun_cnt = cnt;
`else
  assign underrun_cnt = '0;
`endif

endmodule

// File: tb/tb_serializer_gearbox.sv
// Scoreboard bench for serializer_gearbox: 3-lane ratio-5 main instance plus ratio-1 and ratio-10 edges.
module tb_serializer_gearbox;

  localparam int unsigned R    = 5;
  localparam logic [9:0]  IDLE = 10'b1101010100;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [29:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_ready, word_start, underrun;
  logic [5:0]  serial_out;
  logic [15:0] underrun_cnt;

  logic [9:0]  r1_data = '0;
  logic        r1_valid = 1'b0;
  logic        r1_ready, r1_ws, r1_ur;
  logic [9:0]  r1_out;
  logic [15:0] r1_cnt;

  logic [9:0]  rb_data = '0;
  logic        rb_valid = 1'b0;
  logic        rb_ready, rb_ws, rb_ur;
  logic [0:0]  rb_out;
  logic [15:0] rb_cnt;

  serializer_gearbox #(.CHANNELS(3), .DATA_W(10), .OUT_W(2), .IDLE_WORD(IDLE)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .serial_out(serial_out), .word_start(word_start), .underrun(underrun),
    .underrun_cnt(underrun_cnt));

  serializer_gearbox #(.CHANNELS(1), .DATA_W(10), .OUT_W(10), .IDLE_WORD(IDLE)) u_r1 (
    .clk(clk), .rst_n(rst_n), .in_data(r1_data), .in_valid(r1_valid), .in_ready(r1_ready),
    .serial_out(r1_out), .word_start(r1_ws), .underrun(r1_ur), .underrun_cnt(r1_cnt));

  serializer_gearbox #(.CHANNELS(1), .DATA_W(10), .OUT_W(1), .IDLE_WORD(IDLE)) u_rb (
    .clk(clk), .rst_n(rst_n), .in_data(rb_data), .in_valid(rb_valid), .in_ready(rb_ready),
    .serial_out(rb_out), .word_start(rb_ws), .underrun(rb_ur), .underrun_cnt(rb_cnt));

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Main-instance scoreboard: accepted words wait here until their load boundary.
  logic [29:0] sb_q[$];
  logic [29:0] m_word;
  int          m_pos;
  bit          m_first;
  int unsigned m_ucnt;
  bit          m_ur_pend;
  bit          go = 1'b0;
  bit          done_r1 = 1'b0;
  bit          done_rb = 1'b0;

  function automatic logic [5:0] slice6(input logic [29:0] w, input int pos);
    logic [5:0] r;
    r = '0;
    for (int c = 0; c < 3; c++) r[c*2 +: 2] = w[c*10 + pos*2 +: 2];
    return r;
  endfunction

  function automatic logic [15:0] exp_cnt(input int unsigned n);
`ifdef SERIALIZER_UNDERRUN_CNT_EN
    return 16'(n);
`else
    return 16'(n & 0);
`endif
  endfunction

  task automatic step();
    bit         bnd, rdy;
    logic [5:0] e_so;
    logic       e_ws, e_ur;
    bnd  = m_first || (m_pos == R - 1);
    rdy  = (sb_q.size() == 0) || bnd;
    check_eq("in_ready", 32'(in_ready), 32'(rdy));
    e_so = m_first ? slice6({3{IDLE}}, 0) : slice6(m_word, m_pos);
    e_ws = !m_first && (m_pos == 0);
    if (bnd) begin
      if (sb_q.size() != 0) begin
        m_word = sb_q.pop_front();
        e_ur   = 1'b0;
      end else begin
        m_word = {3{IDLE}};
        e_ur   = 1'b1;
      end
      m_pos = 0;
    end else begin
      m_pos++;
      e_ur = 1'b0;
    end
    if (in_valid && rdy) sb_q.push_back(in_data);
    if (m_ur_pend && m_ucnt != 32'hFFFF) m_ucnt++;
    m_ur_pend = e_ur;
    m_first   = 1'b0;
    @(posedge clk); #1;
    check_eq("serial_out", 32'(serial_out), 32'(e_so));
    check_eq("word_start", 32'(word_start), 32'(e_ws));
    check_eq("underrun", 32'(underrun), 32'(e_ur));
    check_eq("underrun_cnt", 32'(underrun_cnt), 32'(exp_cnt(m_ucnt)));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_serial_out", 32'(serial_out), 32'h0);
    check_eq("rst_word_start", 32'(word_start), 32'h0);
    check_eq("rst_underrun", 32'(underrun), 32'h0);
    check_eq("rst_underrun_cnt", 32'(underrun_cnt), 32'h0);
    rst_n = 1'b1;
    sb_q.delete();
    m_first = 1'b1;
    m_pos = 0;
    m_ucnt = 0;
    m_ur_pend = 1'b0;
  endtask

  initial begin
    int guard;
    do_reset();
    go = 1'b1;
    repeat (12) step();

    in_valid = 1'b1;
    in_data  = {10'h2A5, 10'h3FF, 10'h000};
    step();
    in_valid = 1'b0;
    in_data  = '1;
    repeat (12) step();

    in_valid = 1'b1;
    for (int k = 0; k < 40; k++) begin
      in_data = 30'($urandom());
      step();
    end

    for (int k = 0; k < 40; k++) begin
      in_valid = 1'($urandom_range(0, 1));
      in_data  = 30'($urandom());
      step();
    end
    in_valid = 1'b0;

    guard = 0;
    while (!(done_r1 && done_rb) && guard < 200) begin
      @(posedge clk);
      guard++;
    end
    #1;
    check_eq("edge_instances_done", 32'({done_r1, done_rb}), 32'h3);

    guard = 0;
    while (m_pos != 0 && guard < 20) begin
      step();
      guard++;
    end
    in_valid = 1'b1;
    in_data  = {10'h155, 10'h0F0, 10'h2A5};
    step();
    in_valid = 1'b0;
    step();
    check_eq("pre_reset_idx", 32'(m_pos), 32'd2);
    check_eq("pre_reset_hold_full", 32'(in_ready), 32'h0);
    do_reset();
    repeat (12) step();

`ifdef SERIALIZER_UNDERRUN_CNT_EN
    repeat (65600) @(posedge clk);
    #1;
    check_eq("r1_cnt_saturated", 32'(r1_cnt), 32'hFFFF);
`else
    check_eq("r1_cnt_tied", 32'(r1_cnt), 32'h0);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  // Ratio 1: a word accepted at edge k is loaded at k+1 and shown after edge k+2.
  typedef struct packed {
    logic [9:0] d;
    logic       idle;
  } r1_ent_t;
  r1_ent_t r1_q[$];

  initial begin
    r1_ent_t e;
    wait (go);
    e = '{d: IDLE, idle: 1'b0};
    r1_q.push_back(e);
    e = '{d: IDLE, idle: 1'b1};
    r1_q.push_back(e);
    for (int k = 0; k < 24; k++) begin
      r1_valid = (k < 10) ? 1'b1 : 1'($urandom_range(0, 1));
      r1_data  = 10'($urandom());
      check_eq("r1_ready", 32'(r1_ready), 32'h1);
      if (r1_valid) e = '{d: r1_data, idle: 1'b0};
      else          e = '{d: IDLE, idle: 1'b1};
      r1_q.push_back(e);
      @(posedge clk); #1;
      check_eq("r1_out", 32'(r1_out), 32'(r1_q[0].d));
      check_eq("r1_word_start", 32'(r1_ws), 32'h1);
      check_eq("r1_underrun", 32'(r1_ur), 32'(r1_q[1].idle));
      void'(r1_q.pop_front());
    end
    r1_valid = 1'b0;
    done_r1  = 1'b1;
  end

  // Ratio 10: the word misses the first boundary, so it follows one idle word.
  initial begin
    logic [9:0] pat;
    int         seen;
    bit         found;
    wait (go);
    pat      = 10'h2A5;
    rb_valid = 1'b1;
    rb_data  = pat;
    check_eq("rb_ready", 32'(rb_ready), 32'h1);
    @(posedge clk); #1;
    rb_valid = 1'b0;
    rb_data  = 10'h3FF;
    seen  = 0;
    found = 1'b0;
    for (int t = 0; t < 40 && !found; t++) begin
      if (rb_ws) seen++;
      if (seen == 2) found = 1'b1;
      else begin
        @(posedge clk); #1;
      end
    end
    check_eq("rb_word_found", 32'(found), 32'h1);
    for (int i = 0; i < 10; i++) begin
      if (i > 0) begin
        @(posedge clk); #1;
      end
      check_eq("rb_bit", 32'(rb_out), 32'(pat[i]));
      check_eq("rb_word_start", 32'(rb_ws), 32'(i == 0));
      check_eq("rb_underrun", 32'(rb_ur), 32'(i == 9));
    end
    check_eq("rb_cnt", 32'(rb_cnt), 32'(exp_cnt(1)));
    done_rb = 1'b1;
  end

endmodule
